div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 164 ++++++++++++++++
 tb/tb_div_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with ROB-age flush and writeback handshake.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit #(
   parameter int XLEN  = 32,
   parameter int ROBW  = 7,
   parameter int PREGW = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic [ROBW-1:0]  robIdx,
   input  logic [PREGW-1:0] rd,
   input  logic             redirect,
   input  logic [ROBW-1:0]  redirectIdx,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [XLEN-1:0]  wb_data,
   output logic [ROBW-1:0]  wb_robIdx,
   output logic [PREGW-1:0] wb_rd,
   output logic             div_end
);
   localparam int CNTW = $clog2(XLEN + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, wb_data_q, wb_data_d;
   logic             is_rem_q, is_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic [ROBW-1:0]  robidx_q, robidx_d;
   logic [PREGW-1:0] rd_q, rd_d;

   logic            signed_op, a_neg, b_neg, div_zero, ovf, early;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   rem_shift, diff;
   logic            kill_op, kill_in, accept, handshake;

   // Younger = same wrap flag and larger index, or different wrap flag and smaller index.
   function automatic logic younger(input logic [ROBW-1:0] a, input logic [ROBW-1:0] b);
      if (a[ROBW-1] == b[ROBW-1]) return a[ROBW-2:0] > b[ROBW-2:0];
      else                        return a[ROBW-2:0] < b[ROBW-2:0];
   endfunction

   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & rs1_data[XLEN-1];
      b_neg     = signed_op & rs2_data[XLEN-1];
      a_mag     = a_neg ? -rs1_data : rs1_data;
      b_mag     = b_neg ? -rs2_data : rs2_data;
      div_zero  = (rs2_data == '0);
      ovf       = signed_op & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
`ifdef DIV_EARLY_OUT_EN
      early     = (a_mag < b_mag);
`else
      early     = 1'b0;
`endif
      kill_op   = redirect & (state_q != S_IDLE) & younger(robidx_q, redirectIdx);
      kill_in   = redirect & younger(robIdx, redirectIdx);
      accept    = en & in_ready & ~kill_in;
      handshake = (state_q == S_DONE) & wb_ready;
      rem_shift = {rem_q, quo_q[XLEN-1]};
      diff      = rem_shift - {1'b0, dsr_q};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dsr_d     = dsr_q;
      wb_data_d = wb_data_q;
      is_rem_d  = is_rem_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      robidx_d  = robidx_q;
      rd_d      = rd_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_BUSY;
               cnt_d    = '0;
               rem_d    = '0;
               quo_d    = a_mag;
               dsr_d    = b_mag;
               is_rem_d = op[1];
               q_neg_d  = a_neg ^ b_neg;
               r_neg_d  = a_neg;
               robidx_d = robIdx;
               rd_d     = rd;
               // Bypass cases preload the final magnitudes and jump the counter to the finish step.
               if (div_zero) begin
                  cnt_d   = CNTW'(XLEN);
                  quo_d   = '1;
                  rem_d   = a_mag;
                  q_neg_d = 1'b0;
               end else if (ovf) begin
                  cnt_d = CNTW'(XLEN);
                  rem_d = '0;
               end else if (early) begin
                  cnt_d = CNTW'(XLEN);
                  quo_d = '0;
                  rem_d = a_mag;
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == CNTW'(XLEN)) begin
               state_d   = S_DONE;
               wb_data_d = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                                    : (q_neg_q ? -quo_q : quo_q);
            end else begin
               cnt_d = cnt_q + CNTW'(1);
               rem_d = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
            end
         end
         S_DONE: begin
            if (handshake) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (kill_op) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         wb_data_q <= '0;
         is_rem_q  <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         robidx_q  <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dsr_q     <= dsr_d;
         wb_data_q <= wb_data_d;
         is_rem_q  <= is_rem_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         robidx_q  <= robidx_d;
         rd_q      <= rd_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign wb_valid  = (state_q == S_DONE);
   assign div_end   = handshake & ~kill_op;
   assign wb_data   = wb_data_q;
   assign wb_robIdx = robidx_q;
   assign wb_rd     = rd_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed, randomized, flush, backpressure and reset scenarios.
module tb_div_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] rs1_data, rs2_data;
   logic [6:0]  robIdx, rd;
   logic        redirect;
   logic [6:0]  redirectIdx;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_data;
   logic [6:0]  wb_robIdx, wb_rd;
   logic        div_end;

   int checks = 0;
   int errors = 0;

   div_unit #(.XLEN(32), .ROBW(7), .PREGW(7)) dut (
      .clk(clk), .rst(rst), .en(en), .in_ready(in_ready), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .robIdx(robIdx), .rd(rd),
      .redirect(redirect), .redirectIdx(redirectIdx), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_data(wb_data), .wb_robIdx(wb_robIdx),
      .wb_rd(wb_rd), .div_end(div_end)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return o[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      ma = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
      mb = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`endif
      return 33;
   endfunction

   function automatic bit is_younger(input logic [6:0] a, input logic [6:0] b);
      logic [5:0] ai, bi;
      ai = a[5:0];
      bi = b[5:0];
      return (a[6] == b[6]) ? (ai > bi) : (ai < bi);
   endfunction

   // Called at posedge+1; returns at accept edge +1.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] rob, input logic [6:0] r);
      op = o; rs1_data = a; rs2_data = b; robIdx = rob; rd = r; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk); #1;
         if (wb_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; en = 1'b0; op = 2'd0; rs1_data = '0; rs2_data = '0; robIdx = '0; rd = '0;
      redirect = 1'b0; redirectIdx = '0; wb_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, wb_valid, div_end} !== 3'b100) begin
         errors++; $display("FAIL reset_ctrl: got in_ready/wb_valid/div_end=%b expected 100", {in_ready, wb_valid, div_end});
      end
      checks++;
      if ({wb_data, wb_robIdx, wb_rd} !== 46'd0) begin
         errors++; $display("FAIL reset_data: got %h/%h/%h expected zeros", wb_data, wb_robIdx, wb_rd);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      logic [1:0]  ops [10] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
      logic [31:0] as  [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd3};
      logic [31:0] bs  [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10};
      logic [31:0] exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
      int lat, elat;
      wb_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         issue(ops[i], as[i], bs[i], 7'(i + 16), 7'(i + 40));
         wait_valid(60, lat);
         elat = ref_lat(ops[i], as[i], bs[i]);
         checks++;
         if (lat !== elat) begin
            errors++; $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, elat);
         end
         checks++;
         if (wb_data !== exp[i] || wb_robIdx !== 7'(i + 16) || wb_rd !== 7'(i + 40) || div_end !== 1'b1) begin
            errors++; $display("FAIL dir_wb[%0d]: got data=%h rob=%h rd=%h end=%b expected %h %h %h 1",
                               i, wb_data, wb_robIdx, wb_rd, div_end, exp[i], 7'(i + 16), 7'(i + 40));
         end
         @(posedge clk); #1;
         checks++;
         if ({wb_valid, div_end, in_ready} !== 3'b001) begin
            errors++; $display("FAIL dir_after[%0d]: got valid/end/ready=%b expected 001", i, {wb_valid, div_end, in_ready});
         end
      end
   endtask

   task automatic test_random;
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [6:0]  rob, r;
      int lat;
      wb_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 1000)); end
            3: b = 32'($urandom_range(1, 255)) ^ {32{b[31]}};
            default: ;
         endcase
         rob = 7'($urandom); r = 7'($urandom);
         issue(o, a, b, rob, r);
         wait_valid(60, lat);
         checks++;
         if (lat !== ref_lat(o, a, b) || wb_data !== ref_div(o, a, b) || wb_robIdx !== rob || wb_rd !== r || div_end !== 1'b1) begin
            errors++; $display("FAIL rand[%0d] op=%0d %h/%h: got lat=%0d data=%h rob=%h rd=%h end=%b expected lat=%0d data=%h rob=%h rd=%h end=1",
                               i, o, a, b, lat, wb_data, wb_robIdx, wb_rd, div_end, ref_lat(o, a, b), ref_div(o, a, b), rob, r);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int lat;
      wb_ready = 1'b0;
      issue(2'd0, 32'd100, 32'd7, 7'h11, 7'h22);
      wait_valid(60, lat);
      checks++;
      if (lat !== 33) begin
         errors++; $display("FAIL bp_lat: got %0d expected 33", lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (wb_valid !== 1'b1 || wb_data !== 32'd14 || wb_robIdx !== 7'h11 || in_ready !== 1'b0 || div_end !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h rob=%h ready=%b end=%b expected 1 0000000e 11 0 0",
                               i, wb_valid, wb_data, wb_robIdx, in_ready, div_end);
         end
      end
      wb_ready = 1'b1;
      #1;
      checks++;
      if (div_end !== 1'b1) begin
         errors++; $display("FAIL bp_end: got %b expected 1", div_end);
      end
      @(posedge clk); #1;
      checks++;
      if ({in_ready, div_end, wb_valid} !== 3'b100) begin
         errors++; $display("FAIL bp_release: got ready/end/valid=%b expected 100", {in_ready, div_end, wb_valid});
      end
   endtask

   task automatic test_busy_ignore;
      int lat;
      wb_ready = 1'b1;
      issue(2'd0, 32'hFFFF_FF9C, 32'd7, 7'h0A, 7'h05);
      repeat (5) @(posedge clk);
      #1;
      issue(2'd3, 32'd999, 32'd13, 7'h3F, 7'h3F);
      wait_valid(60, lat);
      checks++;
      if (lat !== 27 || wb_data !== 32'hFFFF_FFF2 || wb_robIdx !== 7'h0A || wb_rd !== 7'h05) begin
         errors++; $display("FAIL busy_ignore: got lat=%0d data=%h rob=%h rd=%h expected 27 fffffff2 0a 05",
                            lat, wb_data, wb_robIdx, wb_rd);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_kill;
      logic [6:0] robs  [4] = '{7'h05, 7'h05, 7'h45, 7'h02};
      logic [6:0] redir [4] = '{7'h03, 7'h05, 7'h05, 7'h45};
      logic [6:0] rob, rdi;
      bit killed;
      int lat;
      wb_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin rob = robs[i]; rdi = redir[i]; end
         else begin rob = 7'($urandom); rdi = 7'($urandom); end
         killed = is_younger(rob, rdi);
         issue(2'd1, 32'd1000, 32'd3, rob, 7'h01);
         repeat (9) @(posedge clk);
         #1;
         redirect = 1'b1; redirectIdx = rdi;
         @(posedge clk); #1;
         redirect = 1'b0;
         checks++;
         if (in_ready !== killed || wb_valid !== 1'b0) begin
            errors++; $display("FAIL kill_state[%0d] rob=%h redir=%h: got ready=%b valid=%b expected ready=%b valid=0",
                               i, rob, rdi, in_ready, wb_valid, killed);
         end
         wait_valid(40, lat);
         checks++;
         if ((lat != -1) !== !killed || (!killed && (wb_data !== 32'd333 || lat !== 23))) begin
            errors++; $display("FAIL kill_wb[%0d] rob=%h redir=%h: got lat=%0d data=%h expected completes=%0d data=0000014d lat=23",
                               i, rob, rdi, lat, wb_data, !killed);
         end
         if (lat != -1) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_kill_handshake;
      int lat;
      wb_ready = 1'b0;
      issue(2'd1, 32'd50, 32'd5, 7'h08, 7'h03);
      wait_valid(60, lat);
      redirect = 1'b1; redirectIdx = 7'h01; wb_ready = 1'b1;
      #1;
      checks++;
      if (div_end !== 1'b0 || lat !== 33) begin
         errors++; $display("FAIL kill_hs_end: got end=%b lat=%0d expected 0 33", div_end, lat);
      end
      @(posedge clk); #1;
      redirect = 1'b0;
      checks++;
      if ({wb_valid, in_ready, div_end} !== 3'b010) begin
         errors++; $display("FAIL kill_hs_state: got valid/ready/end=%b expected 010", {wb_valid, in_ready, div_end});
      end
   endtask

   task automatic test_accept_kill;
      int lat;
      redirect = 1'b1; redirectIdx = 7'h03;
      issue(2'd1, 32'd20, 32'd3, 7'h06, 7'h01);
      redirect = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL accept_kill_ready: got %b expected 1", in_ready);
      end
      wait_valid(40, lat);
      checks++;
      if (lat !== -1) begin
         errors++; $display("FAIL accept_kill_wb: got wb_valid at cycle %0d expected none", lat);
      end
   endtask

   task automatic test_reset_mid;
      int lat;
      wb_ready = 1'b1;
      issue(2'd0, 32'd100, 32'd7, 7'h33, 7'h44);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({in_ready, wb_valid, div_end} !== 3'b100 || {wb_data, wb_robIdx, wb_rd} !== 46'd0) begin
         errors++; $display("FAIL reset_mid: got ready/valid/end=%b data=%h rob=%h rd=%h expected 100 zeros",
                            {in_ready, wb_valid, div_end}, wb_data, wb_robIdx, wb_rd);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      wait_valid(40, lat);
      checks++;
      if (lat !== -1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid_after: got lat=%0d ready=%b expected none 1", lat, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_busy_ignore();
      test_kill();
      test_kill_handshake();
      test_accept_kill();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
